rgb_led_pwm_ctrl: RTL and testbench

//  Memory-mapped PWM controller for the board's RED/GREEN/BLUE LED pins.

---
 rtl/rgb_led_pwm_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_rgb_led_pwm_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_pwm_ctrl.sv
// rtl/rgb_led_pwm_ctrl.sv - three-channel RGB LED PWM controller with shared prescaler and breathe fade
module rgb_led_pwm_ctrl #(
    parameter int CLOCK_FREQ = 12000000,
    parameter int PWM_FREQ   = 1000
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic [3:0]  ADDRESS,
    input  logic [15:0] DATA_IN,
    input  logic        WR,
    output logic [15:0] DATA_OUT,
    output logic        LED_R,
    output logic        LED_G,
    output logic        LED_B
);

    localparam int          PRESCALE_DEF = CLOCK_FREQ / (PWM_FREQ * 256) - 1;
    localparam logic [15:0] PRESCALE_RST = PRESCALE_DEF[15:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    logic [2:0]  ctrl;
    logic [15:0] prescale;
    logic [7:0]  duty_r, duty_g, duty_b;
    logic [15:0] step;

    logic [7:0]  shadow_r, shadow_g, shadow_b;
    logic [15:0] presc_cnt;
    logic [7:0]  pwm_cnt;
    logic [15:0] step_cnt, step_cnt_n;
    logic [7:0]  level, level_n;
    state_t      state, state_n;

    logic        en, breathe, inv;
    logic        tick, period_end, en_rise_wr, step_hit;
    logic [8:0]  lvl_eff;
    logic [15:0] prod_r, prod_g, prod_b;
    logic [7:0]  e_r, e_g, e_b;
    logic        raw_r, raw_g, raw_b;
    logic [15:0] status;

    assign en      = ctrl[0];
    assign breathe = ctrl[1];
    assign inv     = ctrl[2];

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            ctrl     <= 3'd0;
            prescale <= PRESCALE_RST;
            duty_r   <= 8'd0;
            duty_g   <= 8'd0;
            duty_b   <= 8'd0;
            step     <= 16'd0;
        end else if (WR) begin
            case (ADDRESS)
                4'd0:    ctrl     <= DATA_IN[2:0];
                4'd1:    prescale <= DATA_IN;
                4'd2:    duty_r   <= DATA_IN[7:0];
                4'd3:    duty_g   <= DATA_IN[7:0];
                4'd4:    duty_b   <= DATA_IN[7:0];
                4'd5:    step     <= DATA_IN;
                default: ;
            endcase
        end
    end

    // >= rather than == so a shrinking PRESCALE never strands the counter above it
    assign tick       = en && (presc_cnt >= prescale);
    assign period_end = tick && (pwm_cnt == 8'hff);
    // Shadows load on the same edge EN is written 1, so the first period uses fresh duties
    assign en_rise_wr = WR && (ADDRESS == 4'd0) && DATA_IN[0] && !en;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            presc_cnt <= 16'd0;
            pwm_cnt   <= 8'd0;
        end else if (!en) begin
            presc_cnt <= 16'd0;
            pwm_cnt   <= 8'd0;
        end else if (tick) begin
            presc_cnt <= 16'd0;
            pwm_cnt   <= pwm_cnt + 8'd1;
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            shadow_r <= 8'd0;
            shadow_g <= 8'd0;
            shadow_b <= 8'd0;
        end else if (en_rise_wr || period_end) begin
            shadow_r <= duty_r;
            shadow_g <= duty_g;
            shadow_b <= duty_b;
        end
    end

    assign step_hit = ({1'b0, step_cnt} + 17'd1) >= {1'b0, step};

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state    <= ST_IDLE;
            level    <= 8'd0;
            step_cnt <= 16'd0;
        end else begin
            state    <= state_n;
            level    <= level_n;
            step_cnt <= step_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        level_n    = level;
        step_cnt_n = step_cnt;
        if (!en || !breathe) begin
            state_n    = ST_IDLE;
            level_n    = 8'd0;
            step_cnt_n = 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n    = ST_UP;
                    level_n    = 8'd0;
                    step_cnt_n = 16'd0;
                end
                ST_UP: begin
                    if (level == 8'hff) begin
                        state_n = ST_DOWN;
                    end else if (period_end) begin
                        if (step_hit) begin
                            step_cnt_n = 16'd0;
                            level_n    = level + 8'd1;
                        end else begin
                            step_cnt_n = step_cnt + 16'd1;
                        end
                    end
                end
                ST_DOWN: begin
                    if (level == 8'h00) begin
                        state_n = ST_UP;
                    end else if (period_end) begin
                        if (step_hit) begin
                            step_cnt_n = 16'd0;
                            level_n    = level - 8'd1;
                        end else begin
                            step_cnt_n = step_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state_n    = ST_IDLE;
                    level_n    = 8'd0;
                    step_cnt_n = 16'd0;
                end
            endcase
        end
    end

    // Idle uses a gain of 256 so the scaled duty equals the shadow duty exactly
    assign lvl_eff = (state == ST_IDLE) ? 9'd256 : {1'b0, level};
    assign prod_r  = {8'd0, shadow_r} * {7'd0, lvl_eff};
    assign prod_g  = {8'd0, shadow_g} * {7'd0, lvl_eff};
    assign prod_b  = {8'd0, shadow_b} * {7'd0, lvl_eff};
    assign e_r     = 8'(prod_r >> 8);
    assign e_g     = 8'(prod_g >> 8);
    assign e_b     = 8'(prod_b >> 8);

    assign raw_r = en && (pwm_cnt < e_r);
    assign raw_g = en && (pwm_cnt < e_g);
    assign raw_b = en && (pwm_cnt < e_b);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            LED_R <= 1'b0;
            LED_G <= 1'b0;
            LED_B <= 1'b0;
        end else begin
            LED_R <= raw_r ^ inv;
            LED_G <= raw_g ^ inv;
            LED_B <= raw_b ^ inv;
        end
    end

    assign status = {5'd0, state, (state == ST_DOWN), level};

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            DATA_OUT <= 16'd0;
        end else begin
            case (ADDRESS)
                4'd0:    DATA_OUT <= {13'd0, ctrl};
                4'd1:    DATA_OUT <= prescale;
                4'd2:    DATA_OUT <= {8'd0, duty_r};
                4'd3:    DATA_OUT <= {8'd0, duty_g};
                4'd4:    DATA_OUT <= {8'd0, duty_b};
                4'd5:    DATA_OUT <= step;
                4'd6:    DATA_OUT <= status;
                default: DATA_OUT <= 16'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// tb/tb_rgb_led_pwm_ctrl.sv - directed self-checking bench for rgb_led_pwm_ctrl
module tb_rgb_led_pwm_ctrl;

    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic [3:0]  ADDRESS = 4'd0;
    logic [15:0] DATA_IN = 16'd0;
    logic        WR = 1'b0;
    logic [15:0] DATA_OUT;
    logic        LED_R, LED_G, LED_B;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    rgb_led_pwm_ctrl dut (
        .CLK      (CLK),
        .RSTb     (RSTb),
        .ADDRESS  (ADDRESS),
        .DATA_IN  (DATA_IN),
        .WR       (WR),
        .DATA_OUT (DATA_OUT),
        .LED_R    (LED_R),
        .LED_G    (LED_G),
        .LED_B    (LED_B)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge CLK);
        ADDRESS = a;
        DATA_IN = d;
        WR      = 1'b1;
        @(negedge CLK);
        WR      = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [15:0] d);
        @(negedge CLK);
        ADDRESS = a;
        @(negedge CLK);
        d = DATA_OUT;
    endtask

    task automatic count_leds(input int n, output int r, output int g, output int b);
        r = 0; g = 0; b = 0;
        repeat (n) begin
            @(negedge CLK);
            WR = 1'b0;
            r += int'(LED_R);
            g += int'(LED_G);
            b += int'(LED_B);
        end
    endtask

    // Waits for the STATUS level to move off prev; returns detection cycle or -1 on timeout
    task automatic wait_level_change(input logic [7:0] prev, output int t);
        int n;
        t = -1;
        n = 0;
        while (t < 0 && n < 400) begin
            @(negedge CLK);
            n++;
            if (DATA_OUT[7:0] != prev) t = cyc;
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [7:0]  prev;
        int r, g, b, t, last_t;

        repeat (3) @(negedge CLK);
        check_eq("rst_led_r", LED_R, 0);
        check_eq("rst_led_g", LED_G, 0);
        check_eq("rst_led_b", LED_B, 0);
        check_eq("rst_data_out", DATA_OUT, 0);
        RSTb = 1'b1;

        reg_read(4'd1, rd); check_eq("rst_prescale", rd, 45);
        reg_read(4'd7, rd); check_eq("rd_unmapped", rd, 0);
        reg_read(4'd0, rd); check_eq("rst_ctrl", rd, 0);
        reg_read(4'd6, rd); check_eq("rst_status", rd, 0);
        reg_write(4'd7, 16'hffff);
        reg_read(4'd7, rd); check_eq("wr_unmapped", rd, 0);

        // Basic duty on red
        reg_write(4'd1, 16'd0);
        reg_write(4'd2, 16'd64);
        reg_write(4'd0, 16'd1);
        count_leds(256, r, g, b);
        check_eq("p1_r64", r, 64);
        check_eq("p1_g0", g, 0);
        check_eq("p1_b0", b, 0);
        count_leds(256, r, g, b);
        check_eq("p2_r64", r, 64);
        reg_read(4'd0, rd); check_eq("rd_ctrl", rd, 1);

        // Mid-period duty write is deferred to the next period
        reg_write(4'd0, 16'd0);
        reg_write(4'd3, 16'd200);
        reg_write(4'd0, 16'd1);
        count_leds(50, r, g, b);
        check_eq("mid_g_head", g, 50);
        check_eq("mid_r_head", r, 50);
        ADDRESS = 4'd3;
        DATA_IN = 16'd10;
        WR      = 1'b1;
        count_leds(206, r, g, b);
        check_eq("mid_g_tail", g, 150);
        check_eq("mid_r_tail", r, 14);
        check_eq("mid_b_tail", b, 0);
        count_leds(256, r, g, b);
        check_eq("next_g10", g, 10);
        check_eq("next_r64", r, 64);
        reg_read(4'd3, rd); check_eq("rd_duty_g", rd, 10);

        // Full-scale blue, disabled-with-INV level, inverted waveforms
        reg_write(4'd0, 16'd0);
        reg_write(4'd4, 16'd255);
        reg_write(4'd0, 16'd1);
        count_leds(256, r, g, b);
        check_eq("b255_b", b, 255);
        check_eq("b255_r", r, 64);
        check_eq("b255_g", g, 10);
        reg_write(4'd0, 16'd4);
        count_leds(4, r, g, b);
        check_eq("dis_inv_r", r, 4);
        check_eq("dis_inv_g", g, 4);
        check_eq("dis_inv_b", b, 4);
        reg_write(4'd0, 16'd5);
        count_leds(256, r, g, b);
        check_eq("inv_r", r, 192);
        check_eq("inv_g", g, 246);
        check_eq("inv_b", b, 1);
        reg_write(4'd0, 16'd0);
        count_leds(4, r, g, b);
        check_eq("dis_r", r, 0);
        check_eq("dis_b", b, 0);

        // Breathe: level climbs one per period to 255, then turns down
        reg_write(4'd5, 16'd0);
        reg_write(4'd2, 16'd255);
        reg_write(4'd0, 16'd3);
        ADDRESS = 4'd6;
        prev    = 8'd0;
        last_t  = -1;
        for (int lv = 1; lv <= 255; lv++) begin
            wait_level_change(prev, t);
            check_eq("breathe_up_level", DATA_OUT[7:0], lv);
            if (t < 0) break;
            if (last_t >= 0) check_eq("breathe_up_interval", t - last_t, 256);
            if (lv == 128) check_eq("breathe_up_dir", DATA_OUT[8], 0);
            last_t = t;
            prev   = DATA_OUT[7:0];
        end
        repeat (3) @(negedge CLK);
        check_eq("breathe_top_level", DATA_OUT[7:0], 255);
        check_eq("breathe_top_dir", DATA_OUT[8], 1);
        check_eq("breathe_top_state", DATA_OUT[10:9], 2);
        prev = 8'd255;
        for (int lv = 254; lv >= 252; lv--) begin
            wait_level_change(prev, t);
            check_eq("breathe_down_level", DATA_OUT[7:0], lv);
            if (t < 0) break;
            check_eq("breathe_down_interval", t - last_t, 256);
            check_eq("breathe_down_dir", DATA_OUT[8], 1);
            last_t = t;
            prev   = DATA_OUT[7:0];
        end
        reg_write(4'd0, 16'd1);
        reg_read(4'd6, rd); check_eq("breathe_off_status", rd, 0);

        // Asynchronous reset while red is lit
        reg_write(4'd0, 16'd0);
        reg_write(4'd1, 16'd7);
        reg_write(4'd0, 16'd1);
        repeat (20) @(negedge CLK);
        check_eq("pre_rst_led_r", LED_R, 1);
        #2;
        RSTb = 1'b0;
        #1;
        check_eq("async_rst_led_r", LED_R, 0);
        check_eq("async_rst_data_out", DATA_OUT, 0);
        @(negedge CLK);
        RSTb = 1'b1;
        reg_read(4'd1, rd); check_eq("post_rst_prescale", rd, 45);
        reg_read(4'd0, rd); check_eq("post_rst_ctrl", rd, 0);
        check_eq("post_rst_led_r", LED_R, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
